// File: rtl/opl3_ctl_pkg.sv
// Shared types and constants for the OPL3 write scheduler.
package opl3_ctl_pkg;

   localparam int unsigned IDX_W     = 9;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned REG_COUNT = 512;
   localparam int unsigned INIT_W    = 10;

   // Port address bit 0: address phase vs data phase
   localparam logic OPL_PORT_ADDR = 1'b0;
   localparam logic OPL_PORT_DATA = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_AWAIT,
      ST_DATA,
      ST_DWAIT
   } state_t;

   // One captured register write
   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/opl3_rr_arb.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module opl3_rr_arb
   import opl3_ctl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       en,
   output logic [1:0] grant_c
);

   logic last_b;

   // Grant a lone requester, or the one not served last on a tie
   always_comb begin
      grant_c = 2'b00;
      if (en) begin
         if (valid[0] && (!valid[1] || last_b)) begin
            grant_c = 2'b01;
         end else if (valid[1]) begin
            grant_c = 2'b10;
         end
      end
   end

   // Last-served pointer; starts as "B last" so A wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b <= 1'b1;
      end else if (grant_c != 2'b00) begin
         last_b <= grant_c[1];
      end
   end

endmodule

// File: rtl/opl3_write_sched.sv
// Write scheduler driving the OPL3 CPU port: address/data pulse sequencing,
// requester arbitration and an optional clear-all sweep after reset.
module opl3_write_sched
   import opl3_ctl_pkg::*;
#(
   parameter int unsigned ADDR_WAIT = 2,
   parameter int unsigned DATA_WAIT = 2,
   parameter bit          INIT_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [IDX_W-1:0]  a_index,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [IDX_W-1:0]  b_index,
   input  logic [DATA_W-1:0] b_data,
   output logic [1:0]        opl_addr,
   output logic [7:0]        opl_din,
   output logic              opl_we,
   output logic              busy,
   output logic              init_done
);

   localparam int unsigned MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
   wr_req_t             req_q, req_d, sel_req;
   logic [1:0]          grant_c;
   logic [1:0]          addr_d;
   logic [7:0]          din_d;
   logic                we_d, init_done_d, busy_d;

   // Requesters are only offered a slot when idle and the sweep is over
   opl3_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   ({b_valid, a_valid}),
      .en      ((state_q == ST_IDLE) && init_done),
      .grant_c (grant_c)
   );

   assign a_ready = grant_c[0];
   assign b_ready = grant_c[1];

   // Payload of whichever requester is granted
   always_comb begin
      sel_req.idx  = grant_c[1] ? b_index : a_index;
      sel_req.data = grant_c[1] ? b_data  : a_data;
   end

   // Next state plus next values of the registered bus outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_cnt_d  = init_cnt_q;
      req_d       = req_q;
      addr_d      = opl_addr;
      din_d       = opl_din;
      we_d        = 1'b0;
      init_done_d = init_done;

      unique case (state_q)
         ST_IDLE: begin
            if (!init_done) begin
               if (!INIT_EN) begin
                  init_done_d = 1'b1;
               end else begin
                  req_d.idx  = init_cnt_q[IDX_W-1:0];
                  req_d.data = '0;
                  init_cnt_d = init_cnt_q + INIT_W'(1);
                  state_d    = ST_ADDR;
               end
            end else if (grant_c != 2'b00) begin
               req_d   = sel_req;
               state_d = ST_ADDR;
            end
            if (state_d == ST_ADDR) begin
               we_d   = 1'b1;
               addr_d = {req_d.idx[8], OPL_PORT_ADDR};
               din_d  = req_d.idx[7:0];
            end
         end
         ST_ADDR: begin
            cnt_d   = CNT_W'(ADDR_WAIT - 1);
            state_d = ST_AWAIT;
         end
         ST_AWAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DATA;
               we_d    = 1'b1;
               addr_d  = {req_q.idx[8], OPL_PORT_DATA};
               din_d   = req_q.data;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DATA: begin
            cnt_d   = CNT_W'(DATA_WAIT - 1);
            state_d = ST_DWAIT;
         end
         ST_DWAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (init_cnt_q[INIT_W-1]) begin
                  init_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE) || !init_done_d;
   end

   // State, capture and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         init_cnt_q <= '0;
         req_q      <= '0;
         opl_addr   <= '0;
         opl_din    <= '0;
         opl_we     <= 1'b0;
         init_done  <= 1'b0;
         busy       <= INIT_EN;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         init_cnt_q <= init_cnt_d;
         req_q      <= req_d;
         opl_addr   <= addr_d;
         opl_din    <= din_d;
         opl_we     <= we_d;
         init_done  <= init_done_d;
         busy       <= busy_d;
      end
   end

endmodule
